// File: rtl/instr_register_pkg.sv
// Shared instruction-register types and constants used by the readback checker,
// its expected-result calculator and the benches around them.
package instr_register_pkg;

  localparam int NUM_IR_ENTRIES = 32;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  result;
  } instruction_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } chk_state_t;

endpackage

// File: rtl/instr_readback_checker_if.sv
// Sweep control, instruction-register read port and result reporting of the
// readback checker, bundled with driver (master) and checker (slave) views.
interface instr_readback_checker_if #(
  parameter int CNT_W = 6
);
  import instr_register_pkg::*;

  logic               start;
  address_t           first_ptr;
  logic [CNT_W-1:0]   count;
  instruction_t       instruction_word;
  address_t           read_pointer;
  logic               busy;
  logic               done;
  logic               mismatch;
  address_t           mismatch_ptr;
  result_t            mismatch_expected;
  logic [CNT_W-1:0]   pass_count;
  logic [CNT_W-1:0]   fail_count;

  modport master (
    output start, first_ptr, count, instruction_word,
    input  read_pointer, busy, done, mismatch, mismatch_ptr, mismatch_expected,
           pass_count, fail_count
  );

  modport slave (
    input  start, first_ptr, count, instruction_word,
    output read_pointer, busy, done, mismatch, mismatch_ptr, mismatch_expected,
           pass_count, fail_count
  );

endinterface

// File: rtl/instr_expected_calc.sv
// Combinational recomputation of an instruction's result from its opcode and
// operands; operands are sign-extended and evaluated as signed 64-bit values.
module instr_expected_calc
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output result_t      expected
);

  result_t a_s;
  result_t b_s;
  logic    unused_result_s;

  assign unused_result_s = ^instr.result;

  // Opcode decode; non-positive divisors yield zero instead of trapping.
  always_comb begin
    a_s      = {{32{instr.op_a[31]}}, instr.op_a};
    b_s      = {{32{instr.op_b[31]}}, instr.op_b};
    expected = 64'sd0;
    case (instr.opc)
      ZERO:  expected = 64'sd0;
      PASSA: expected = a_s;
      PASSB: expected = b_s;
      ADD:   expected = a_s + b_s;
      SUB:   expected = a_s - b_s;
      MULT:  expected = a_s * b_s;
      DIV: begin
        if (b_s <= 64'sd0) expected = 64'sd0;
        else               expected = a_s / b_s;
      end
      MOD: begin
        if (b_s <= 64'sd0) expected = 64'sd0;
        else               expected = a_s % b_s;
      end
      default: expected = 64'sd0;
    endcase
  end

endmodule

// File: rtl/instr_readback_checker.sv
// Sweeps a window of the instruction register, recomputes each entry's result
// and reports mismatches plus pass/fail totals; one entry per cycle, 2-edge latency.
module instr_readback_checker
  import instr_register_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_IR_ENTRIES,
  parameter int CNT_W       = 6
) (
  input logic                     clk,
  input logic                     reset_n,
  instr_readback_checker_if.slave bus
);

  chk_state_t       state_r;
  chk_state_t       state_nxt_s;
  logic             accept_s;
  logic             issue_s;
  logic             finish_s;
  logic [CNT_W-1:0] count_clamped_s;
  address_t         ptr_inc_s;

  logic [CNT_W-1:0] remaining_r;
  address_t         read_pointer_r;
  logic             busy_r;
  logic             done_r;

  logic             s1_valid_r;
  instruction_t     s1_word_r;
  address_t         s1_ptr_r;

  result_t          expected_s;
  logic             match_s;
  logic             mismatch_r;
  address_t         mismatch_ptr_r;
  result_t          mismatch_expected_r;
  logic [CNT_W-1:0] pass_count_r;
  logic [CNT_W-1:0] fail_count_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    else                    return v + CNT_W'(1);
  endfunction

  // Count clamp and pointer wrap helpers.
  always_comb begin
    count_clamped_s = bus.count;
    if (bus.count > CNT_W'(NUM_ENTRIES)) count_clamped_s = CNT_W'(NUM_ENTRIES);
    else                                 count_clamped_s = bus.count;
    if (read_pointer_r == address_t'(NUM_ENTRIES - 1)) ptr_inc_s = 5'd0;
    else                                               ptr_inc_s = read_pointer_r + 5'd1;
  end

  // Sweep FSM next-state and control strobes; an empty sweep skips ISSUE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          if (count_clamped_s == CNT_W'(0)) state_nxt_s = ST_DRAIN;
          else                              state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s = 1'b1;
        if (remaining_r == CNT_W'(1)) state_nxt_s = ST_DRAIN;
        else                          state_nxt_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        finish_s    = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Address issue, remaining count and busy/done handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer_r <= 5'd0;
      remaining_r    <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (accept_s) begin
        read_pointer_r <= bus.first_ptr;
        remaining_r    <= count_clamped_s;
        busy_r         <= (count_clamped_s != CNT_W'(0));
      end else if (issue_s) begin
        read_pointer_r <= ptr_inc_s;
        remaining_r    <= remaining_r - CNT_W'(1);
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Stage 1: capture the word returned for the address presented last cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_word_r  <= '0;
      s1_ptr_r   <= 5'd0;
    end else begin
      s1_valid_r <= issue_s;
      if (issue_s) begin
        s1_word_r <= bus.instruction_word;
        s1_ptr_r  <= read_pointer_r;
      end
    end
  end

  instr_expected_calc u_calc (
    .instr    (s1_word_r),
    .expected (expected_s)
  );

  assign match_s = (expected_s == s1_word_r.result);

  // Stage 2: compare, report mismatches and update saturating totals.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_r          <= 1'b0;
      mismatch_ptr_r      <= 5'd0;
      mismatch_expected_r <= 64'sd0;
      pass_count_r        <= '0;
      fail_count_r        <= '0;
    end else begin
      mismatch_r <= s1_valid_r && !match_s;
      if (accept_s) begin
        pass_count_r <= '0;
        fail_count_r <= '0;
      end else if (s1_valid_r) begin
        if (match_s) begin
          pass_count_r <= sat_inc(pass_count_r);
        end else begin
          fail_count_r        <= sat_inc(fail_count_r);
          mismatch_ptr_r      <= s1_ptr_r;
          mismatch_expected_r <= expected_s;
        end
      end
    end
  end

  assign bus.read_pointer      = read_pointer_r;
  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.mismatch          = mismatch_r;
  assign bus.mismatch_ptr      = mismatch_ptr_r;
  assign bus.mismatch_expected = mismatch_expected_r;
  assign bus.pass_count        = pass_count_r;
  assign bus.fail_count        = fail_count_r;

endmodule

// File: doc/instr_readback_checker.md
Name: instr_readback_checker

Overview:
- Downstream stage of the instruction register. It sweeps `read_pointer` over a programmed window of entries and captures each returned `instruction_word`.
- For each entry it recomputes the expected result from the stored opcode and operands, then compares that against the stored result.
- It reports per-entry mismatches plus pass/fail totals.
- It serves as the built-in self-check for loaded instruction batches, in both the testbench and the bring-up harness.

Parameters:
- NUM_ENTRIES, 32, depth of the instruction register; the pointer wraps modulo this value.
- CNT_W, 6, width of the `count` input and of `pass_count`/`fail_count`; must hold NUM_ENTRIES.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE
- first_ptr  in  address_t (5)  first entry to check
- count  in  CNT_W  number of entries to check; valid range 0..NUM_ENTRIES
- instruction_word  in  instruction_t  word returned by the instruction register for the current `read_pointer`
- read_pointer  out  address_t  registered read address
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse marking the end of a sweep
- mismatch  out  1  one-cycle pulse when a checked entry fails
- mismatch_ptr  out  address_t  address of the failing entry; valid while `mismatch`=1
- mismatch_expected  out  result_t  expected result for the failing entry; valid while `mismatch`=1
- pass_count  out  CNT_W  entries passed in the current/last sweep
- fail_count  out  CNT_W  entries failed in the current/last sweep

Behaviour:
- Reset is `reset_n`, asynchronous, active-low; clock is `clk`.
- Reset values:
  - `read_pointer`=0, `busy`=0, `done`=0, `mismatch`=0, `mismatch_ptr`=0, `mismatch_expected`=0, `pass_count`=0, `fail_count`=0.
  - FSM goes to IDLE; all pipeline valids are cleared.
- FSM has three states:
  - IDLE: waits for `start`.
  - ISSUE: presents one address per cycle.
  - DRAIN: waits for in-flight compares to finish.
- Start acceptance (edge E0, `start`=1 in IDLE):
  - `pass_count` and `fail_count` clear to 0.
  - `read_pointer`<=`first_ptr`; the internal remaining count <=`count`.
  - `busy`<=1; FSM goes to ISSUE.
- `count`=0 at start: no ISSUE state. `done` pulses high in the cycle after E0; `busy` stays 0; counters clear.
- ISSUE:
  - `read_pointer` increments every edge, modulo NUM_ENTRIES (31 wraps to 0).
  - After `count` addresses have been presented, the FSM goes to DRAIN.
- Pipeline stage 1: at the edge following pointer P, capture `instruction_word` and P into s1 registers and set s1_valid.
- Pipeline stage 2:
  - At the next edge, compare the computed expected value against s1 `.result`.
  - On a match: `pass_count`++.
  - On a mismatch: `fail_count`++, `mismatch`<=1, `mismatch_ptr`<=P, `mismatch_expected`<=expected.
- Throughput is one entry per cycle. Latency from `read_pointer`=P to its `mismatch`/counter update is 2 edges.
- Completion: `done` pulses and `busy` falls at the edge E(count+1), the same edge as the final counter update. The FSM then returns to IDLE.
- Expected-result rules (operands sign-extended to result_t, signed arithmetic in result_t width):
  - ZERO→0
  - PASSA→a
  - PASSB→b
  - ADD→a+b
  - SUB→a−b
  - MULT→a*b
  - DIV→(b<=0 ? 0 : a/b)
  - MOD→(b<=0 ? 0 : a%b)
  - any undefined opcode encoding→0
- Counters saturate at 2^CNT_W−1 and never wrap.
- `start` while busy is ignored, with no effect on the pointer, counters or FSM.
- `count` > NUM_ENTRIES: clamp to NUM_ENTRIES.
- Reset asserted mid-sweep: immediate return to reset values; no `done` pulse. The next sweep requires a new `start`.
- Counters and `mismatch_ptr` hold their values in IDLE until the next accepted `start`.

Decomposition:
- Shared package `instr_register_pkg` holds the types: `opcode_t` (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD), `operand_t` (signed 32), `result_t` (signed 64), `address_t` (5), `instruction_t` {opc, op_a, op_b, result}.
- A new constant `NUM_IR_ENTRIES`=32 also belongs in that package.
- One sub-module, `instr_expected_calc`: purely combinational. It takes an `instruction_t` and returns the expected `result_t`. It is reused as the bench golden model.

Test Plan:
- Preload entries 0..3 with ADD 5+3=8, SUB 5−7=−2, MULT 4*6=24, PASSB 9; start `first_ptr`=0, `count`=4 → `read_pointer` 0,1,2,3; `done` at edge 5; `pass_count`=4, `fail_count`=0; no `mismatch`.
- Entry 2 holds MULT 4*6 with result 25; start `first_ptr`=0, `count`=4 → one `mismatch` pulse with `mismatch_ptr`=2 and `mismatch_expected`=24; `pass_count`=3, `fail_count`=1.
- DIV 7/0, MOD 7/−2 and DIV −9/2, all stored with results 0, 0 and −4 → all pass; `fail_count`=0.
- `first_ptr`=30, `count`=4 → `read_pointer` sequence 30,31,0,1; `done` after 5 edges.
- `count`=0 → `done` pulse one cycle after `start`; `busy` never high; counters 0.
- Reset pulsed at edge E2 of an 8-entry sweep → all outputs return to 0 and no `done` pulse. A `start` pulsed again at edge E3 of a subsequent sweep is ignored and the `read_pointer` sequence stays unbroken.
